// File: rtl/keypad_scanner_if.sv
// Key hand-off bundle between keypad_scanner (master) and its consumer (slave).
// key_code/key_valid/key_ready form a valid/ready handshake; key_down and
// overrun are status signals produced alongside it.
interface keypad_scanner_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
) ();
  localparam int CODE_W = $clog2(ROWS * COLS);

  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_ready;
  logic              key_down;
  logic              overrun;

  modport master (
    output key_code,
    output key_valid,
    output key_down,
    output overrun,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_down,
    input  overrun,
    output key_ready
  );
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives active-low one-hot columns, samples synchronised
// active-low rows once per column dwell, debounces a single closed key, encodes
// it as row*COLS+col+1 and offers it on a valid/ready handshake.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat while a key is held).
module keypad_scanner #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_TICKS = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col_n,
  keypad_scanner_if.master key
);

  localparam int CODE_W = $clog2(ROWS * COLS);
  localparam int RW     = $clog2(ROWS);
  localparam int CW     = $clog2(COLS);
  localparam int DWW    = $clog2(SCAN_DIV);
  localparam int DBW    = $clog2(DEBOUNCE + 1) + 1;

  localparam logic [COLS-1:0] COL_ONE = {{(COLS-1){1'b0}}, 1'b1};
  localparam logic [ROWS-1:0] ROW_ONE = {{(ROWS-1){1'b0}}, 1'b1};

  if (ROWS < 2 || ROWS > 8) begin : g_bad_rows
    $error("keypad_scanner: ROWS must be 2..8");
  end
  if (COLS < 2 || COLS > 8) begin : g_bad_cols
    $error("keypad_scanner: COLS must be 2..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_div
    $error("keypad_scanner: SCAN_DIV must be >= 2");
  end
  if (DEBOUNCE < 1) begin : g_bad_db
    $error("keypad_scanner: DEBOUNCE must be >= 1");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_rep
    $error("keypad_scanner: REPEAT_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_t;

  state_t            state;
  logic [ROWS-1:0]   row_m;
  logic [ROWS-1:0]   row_s;
  logic [DWW-1:0]    dwell;
  logic              tick;
  logic [CW-1:0]     col;
  logic [COLS-1:0]   col_n_q;
  logic [RW-1:0]     lat_row;
  logic [CW-1:0]     lat_col;
  logic [DBW-1:0]    dbcnt;
  logic [DBW-1:0]    relcnt;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic              down_q;
  logic              ovr_q;

  logic [ROWS-1:0]   rows_low;
  logic              one_low;
  logic [RW-1:0]     hit_row;
  logic              same_key;
  logic [CW-1:0]     col_next;
  logic [CODE_W-1:0] new_code;
  logic              emit;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPW = $clog2(REPEAT_TICKS) + 1;
  logic [RPW-1:0]    rep;
`endif

  // Two-flop synchroniser for the asynchronous row pins (idle = all high).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_m <= '1;
      row_s <= '1;
    end else begin
      row_m <= row_n;
      row_s <= row_m;
    end
  end

  // Column dwell counter; tick marks the last clock of each dwell.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dwell <= '0;
    end else if (tick) begin
      dwell <= '0;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  assign tick = (dwell == DWW'(SCAN_DIV - 1));

  // Row decode, next column and code of the latched key.
  always_comb begin
    rows_low = ~row_s;
    one_low  = (rows_low != '0) && ((rows_low & (rows_low - ROW_ONE)) == '0);
    hit_row  = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (rows_low[i]) hit_row = RW'(i);
    end
    same_key = one_low && (hit_row == lat_row);
    col_next = (col == CW'(COLS - 1)) ? '0 : col + 1'b1;
    new_code = CODE_W'(32'(lat_row) * 32'(COLS) + 32'(lat_col) + 32'd1);
  end

  // Emit decision for the current tick (first qualification or auto-repeat).
  always_comb begin
    emit = 1'b0;
    if (tick) begin
      case (state)
        ST_DEBOUNCE: emit = same_key && (dbcnt == DBW'(DEBOUNCE));
`ifdef KEYPAD_AUTOREPEAT_EN
        ST_HELD:     emit = !row_s[lat_row] && (rep == RPW'(REPEAT_TICKS - 1));
`endif
        default:     emit = 1'b0;
      endcase
    end
  end

  // Scan/debounce/hold FSM with registered handshake and status outputs.
  // dbcnt is compared before incrementing so the detection tick counts as the
  // first stable sample and DEBOUNCE further stable ticks are needed to emit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_SCAN;
      col     <= '0;
      col_n_q <= ~COL_ONE;
      lat_row <= '0;
      lat_col <= '0;
      dbcnt   <= '0;
      relcnt  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep     <= '0;
`endif
    end else begin
      ovr_q <= 1'b0;
      if (emit) begin
        code_q  <= new_code;
        valid_q <= 1'b1;
        ovr_q   <= valid_q && !key.key_ready;
      end else if (valid_q && key.key_ready) begin
        valid_q <= 1'b0;
      end

      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (one_low) begin
              lat_row <= hit_row;
              lat_col <= col;
              dbcnt   <= DBW'(1);
              state   <= ST_DEBOUNCE;
            end else begin
              col     <= col_next;
              col_n_q <= ~(COL_ONE << col_next);
            end
          end
          ST_DEBOUNCE: begin
            if (same_key) begin
              if (dbcnt == DBW'(DEBOUNCE)) begin
                down_q <= 1'b1;
                relcnt <= '0;
                state  <= ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep    <= '0;
`endif
              end else begin
                dbcnt <= dbcnt + 1'b1;
              end
            end else begin
              dbcnt   <= '0;
              col     <= col_next;
              col_n_q <= ~(COL_ONE << col_next);
              state   <= ST_SCAN;
            end
          end
          ST_HELD: begin
            if (row_s == '1) begin
              if (relcnt == DBW'(DEBOUNCE - 1)) begin
                relcnt  <= '0;
                down_q  <= 1'b0;
                col     <= col_next;
                col_n_q <= ~(COL_ONE << col_next);
                state   <= ST_SCAN;
              end else begin
                relcnt <= relcnt + 1'b1;
              end
            end else begin
              relcnt <= '0;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            if (!row_s[lat_row]) begin
              rep <= emit ? '0 : rep + 1'b1;
            end else begin
              rep <= '0;
            end
`endif
          end
          default: state <= ST_SCAN;
        endcase
      end
    end
  end

  assign col_n         = col_n_q;
  assign key.key_code  = code_q;
  assign key.key_valid = valid_q;
  assign key.key_down  = down_q;
  assign key.overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a physical keypad model drives the rows,
// stimulus pushes the expected key codes, a negedge monitor pops on each accept.
module tb_keypad_scanner;

  localparam int ROWS         = 4;
  localparam int COLS         = 4;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE     = 2;
  localparam int REPEAT_TICKS = 8;
  localparam int NKEYS        = ROWS * COLS;
  localparam int CODE_W       = $clog2(NKEYS);

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
  logic [NKEYS-1:0] pressed = '0;
  logic            rand_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int ovr_cycles = 0;
  int exp_q[$];

  always #5 clock = ~clock;

  keypad_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kif ();

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .row_n(row_n),
    .col_n(col_n),
    .key(kif)
  );

  // Physical keypad: a closed key pulls its row low when its column is driven.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!col_n[c] && pressed[r*COLS+c]) row_n[r] = 1'b0;
  end

  function automatic int code_of(int r, int c);
    return (r * COLS + c + 1) % (1 << CODE_W);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ticks(int n);
    repeat (n * SCAN_DIV) @(posedge clock);
    #1;
  endtask

  // Monitor: every accepted code must match the head of the expectation queue.
  always @(negedge clock) begin : monitor
    int e;
    if (!reset) begin
      if (kif.overrun) ovr_cycles++;
      if (kif.key_valid && kif.key_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_code: got %0d expected no code", kif.key_code);
        end else begin
          e = exp_q.pop_front();
          check("key_code", int'(kif.key_code), e);
        end
      end
    end
  end

  // Optional random back-pressure on key_ready.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_ready) kif.key_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic press_key(int r, int c, int hold, int rel, bit expect_code);
    if (expect_code) exp_q.push_back(code_of(r, c));
    pressed = '0;
    pressed[r*COLS+c] = 1'b1;
    wait_ticks(hold);
    check("key_down_held", int'(kif.key_down), 1);
    pressed = '0;
    wait_ticks(rel);
    check("key_down_released", int'(kif.key_down), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin : stim
    logic [COLS-1:0] ec;
    logic [COLS-1:0] c0;
    int cyc;
    int rr, cc, hold, emit_tick, n_emit;

    kif.key_ready = 1'b1;

    // Reset values.
    repeat (3) @(posedge clock);
    #1;
    check("reset_col_n", int'(col_n), 4'b1110);
    check("reset_valid", int'(kif.key_valid), 0);
    check("reset_down", int'(kif.key_down), 0);
    check("reset_overrun", int'(kif.overrun), 0);
    check("reset_code", int'(kif.key_code), 0);
    @(negedge clock);
    reset = 1'b0;

    // Idle column rotation, one column per dwell.
    for (int k = 1; k <= 5; k++) begin
      repeat (SCAN_DIV) @(posedge clock);
      #1;
      ec = ~(COLS'(1) << (k % COLS));
      check("col_rotation", int'(col_n), int'(ec));
    end

    // Latency: key r0c0 closed from reset, column 0 driven first.
    reset = 1'b1;
    pressed = '0;
    pressed[0] = 1'b1;
    exp_q.push_back(code_of(0, 0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      #1;
      if (kif.key_valid) begin
        cyc = i;
        break;
      end
    end
    check("first_valid_latency", cyc, (DEBOUNCE + 1) * SCAN_DIV);
    check("down_at_emit", int'(kif.key_down), 1);
    pressed = '0;
    wait_ticks(1);
    check("down_one_tick_after_release", int'(kif.key_down), 1);
    wait_ticks(1);
    check("down_two_ticks_after_release", int'(kif.key_down), 0);
    check("valid_accepted", int'(kif.key_valid), 0);

    // Directed codes, then random keys with random back-pressure.
    press_key(3, 3, 9, DEBOUNCE + 2, 1'b1);
    press_key(1, 2, 9, DEBOUNCE + 2, 1'b1);
    rand_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      rr = $urandom_range(0, ROWS - 1);
      cc = $urandom_range(0, COLS - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
      hold = 9;
`else
      hold = $urandom_range(9, 12);
`endif
      press_key(rr, cc, hold, DEBOUNCE + 2, 1'b1);
    end
    rand_ready = 1'b0;
    @(posedge clock);
    #1;
    kif.key_ready = 1'b1;
    wait_ticks(1);

    // Bounce: key toggles every tick, never stable long enough.
    cc = $urandom_range(0, COLS - 1);
    rr = $urandom_range(0, ROWS - 1);
    for (int t = 0; t < 10; t++) begin
      pressed = '0;
      pressed[rr*COLS+cc] = (t % 2 == 0);
      repeat (SCAN_DIV) @(posedge clock);
    end
    pressed = '0;
    #1;
    check("bounce_no_down", int'(kif.key_down), 0);
    c0 = col_n;
    wait_ticks(1);
    check("bounce_cols_cycling", int'(col_n != c0), 1);
    wait_ticks(2);

    // Ghosting: two rows low on one column is ignored.
    cc = $urandom_range(0, COLS - 1);
    pressed = '0;
    pressed[0*COLS+cc] = 1'b1;
    pressed[2*COLS+cc] = 1'b1;
    wait_ticks(12);
    check("ghost_no_down", int'(kif.key_down), 0);
    c0 = col_n;
    wait_ticks(1);
    check("ghost_cols_cycling", int'(col_n != c0), 1);
    pressed = '0;
    wait_ticks(3);

    // Overrun: code 5 left pending, code 9 overwrites it.
    kif.key_ready = 1'b0;
    ovr_cycles = 0;
    press_key(1, 0, 9, DEBOUNCE + 2, 1'b0);
    press_key(2, 0, 9, DEBOUNCE + 2, 1'b1);
    check("overrun_pulse_cycles", ovr_cycles, 1);
    check("overrun_valid_held", int'(kif.key_valid), 1);
    check("overrun_code", int'(kif.key_code), code_of(2, 0));
    @(posedge clock);
    #1;
    kif.key_ready = 1'b1;
    @(posedge clock);
    #1;
    check("valid_drop_after_accept", int'(kif.key_valid), 0);

    // Long hold of key 6 from reset: one emit, plus repeats when enabled.
    reset = 1'b1;
    pressed = '0;
    pressed[1*COLS+1] = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    emit_tick = (1 + 1) + DEBOUNCE;
`ifdef KEYPAD_AUTOREPEAT_EN
    n_emit = 1 + (30 - emit_tick) / REPEAT_TICKS;
`else
    n_emit = 1;
`endif
    for (int i = 0; i < n_emit; i++) exp_q.push_back(code_of(1, 1));
    repeat (30 * SCAN_DIV) @(posedge clock);
    #1;
    pressed = '0;
    wait_ticks(DEBOUNCE + 2);
    check("hold_queue_drained", exp_q.size(), 0);
    check("hold_released", int'(kif.key_down), 0);

    // Reset mid-operation with a pending code.
    kif.key_ready = 1'b0;
    rr = $urandom_range(0, ROWS - 1);
    cc = $urandom_range(0, COLS - 1);
    pressed = '0;
    pressed[rr*COLS+cc] = 1'b1;
    wait_ticks(9);
    check("pending_before_reset", int'(kif.key_valid), 1);
    #($urandom_range(1, 7));
    reset = 1'b1;
    #1;
    check("async_reset_col_n", int'(col_n), 4'b1110);
    check("async_reset_valid", int'(kif.key_valid), 0);
    check("async_reset_down", int'(kif.key_down), 0);
    exp_q.delete();
    pressed = '0;
    kif.key_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    wait_ticks(4);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
